// File: rtl/switch_allocator.sv
// Five-port switch allocator: per-output round-robin arbitration with
// packet-long grants, flit counting and destination backpressure.
module switch_allocator #(
   parameter int unsigned PACKET_FLITS = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [24:0] request,
   input  logic [4:0]  flit_valid,
   input  logic [4:0]  destination_full,
   output logic [24:0] grant,
   output logic [14:0] xbar_select,
   output logic [4:0]  stall
);

   localparam int unsigned NUM_PORTS = 5;
   localparam int unsigned SEL_W     = 3;
   localparam int unsigned CNT_W     = 8;
   localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(PACKET_FLITS - 1);
   localparam logic [SEL_W-1:0] NO_SEL    = SEL_W'(7);
   localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(NUM_PORTS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   logic [NUM_PORTS-1:0] req_onehot;
   logic [NUM_PORTS-1:0] in_granted;
   logic [NUM_PORTS-1:0] col_req [NUM_PORTS];

   // Index step with wrap from the last port back to port 0
   function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                 input int unsigned step);
      return SEL_W'((32'(base) + step) % NUM_PORTS);
   endfunction

   // Qualify requests: exactly one output bit, and the input holds no grant yet
   always_comb begin
      in_granted = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         req_onehot[i] = $onehot(request[NUM_PORTS*i +: NUM_PORTS]);
         for (int o = 0; o < NUM_PORTS; o++) begin
            in_granted[i] = in_granted[i] | grant[NUM_PORTS*o + i];
         end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            col_req[o][i] = req_onehot[i] & request[NUM_PORTS*i + o] & ~in_granted[i];
         end
      end
   end

   // An input may send only while it owns an output whose downstream has room
   always_comb begin
      stall = '1;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[NUM_PORTS*o + i] && !destination_full[o]) begin
               stall[i] = 1'b0;
            end
         end
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
      state_t               state_q, state_d;
      logic [SEL_W-1:0]     last_winner_q, last_winner_d;
      logic [CNT_W-1:0]     count_q, count_d;
      logic [NUM_PORTS-1:0] gnt_q, gnt_d;
      logic                 pick_found;
      logic [SEL_W-1:0]     pick_idx;
      logic [SEL_W-1:0]     scan_idx;
      logic                 xfer;
      logic [SEL_W-1:0]     sel;

      // Round-robin search beginning just after the previous winner
      always_comb begin
         pick_found = 1'b0;
         pick_idx   = '0;
         scan_idx   = '0;
         for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            scan_idx = wrap_add(last_winner_q, k);
            if (!pick_found && col_req[o][scan_idx]) begin
               pick_found = 1'b1;
               pick_idx   = scan_idx;
            end
         end
      end

      // A flit counts only when the owner sends it unstalled
      always_comb begin
         xfer = (state_q == BUSY) && flit_valid[last_winner_q] && !stall[last_winner_q];
      end

      // Next-state and next-grant for this output
      always_comb begin
         state_d       = state_q;
         last_winner_d = last_winner_q;
         count_d       = count_q;
         gnt_d         = gnt_q;
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_d       = BUSY;
                  last_winner_d = pick_idx;
                  count_d       = '0;
                  gnt_d         = NUM_PORTS'(1) << pick_idx;
               end
            end
            BUSY: begin
               if (xfer) begin
                  if (count_q == LAST_FLIT) begin
                     state_d = IDLE;
                     count_d = '0;
                     gnt_d   = '0;
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
               gnt_d   = '0;
            end
         endcase
      end

      // State register; reset leaves input 0 first in line
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q       <= IDLE;
            last_winner_q <= LAST_PORT;
            count_q       <= '0;
            gnt_q         <= '0;
         end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            count_q       <= count_d;
            gnt_q         <= gnt_d;
         end
      end

      // Crossbar mux select encoded from the registered grant column
      always_comb begin
         sel = NO_SEL;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_q[i]) begin
               sel = SEL_W'(i);
            end
         end
      end

      assign grant[NUM_PORTS*o +: NUM_PORTS] = gnt_q;
      assign xbar_select[SEL_W*o +: SEL_W]   = sel;
   end

endmodule
